final_project_soc_irq_ctrl: RTL and testbench
=============================================

// Module: final_project_soc_irq_ctrl
// PURPOSE
//  Interrupt aggregator directly downstream of the interval timer(s) and other SoC peripherals.
//  Latches up to NUM_SRC interrupt requests as pending, masks them, and priority-encodes them (lowest index wins).
//  Drives one irq_out to the CPU, with a programmable minimum gap between deassertion and reassertion.
//  Registers sit behind a 16-bit Avalon-MM slave with the same read/write timing as the timer's s1 port.
// PARAMETERS
//  NUM_SRC    8   number of irq_in sources; legal range 1..15
//  HOLDOFF_W  16  width of the holdoff counter and the HOLDOFF register (<=16)
// PORTS
//  clk        in   1        system clock; the only clock
//  reset      in   1        synchronous, active-high reset
//  address    in   4        register word index
//  chipselect in   1        slave select
//  write_n    in   1        active-low write strobe; a write is chipselect && ~write_n
//  writedata  in   16       write data
//  readdata   out  16       registered read data
//  irq_in     in   NUM_SRC  level requests from peripherals (timer irq on bit 0); all in the clk domain
//  irq_out    out  1        aggregated interrupt to the CPU
// BEHAVIOUR
//  Reset (sync, active-high) clears all state: pending=0, mask=0, edge_sel=0 (level), holdoff=0,
//   irq_in_d=0, FSM=IDLE, cnt=0, readdata=0, irq_out=0. Reset asserted mid-operation aborts everything on that edge.
//  Register map (bits >= NUM_SRC read as 0, writes to them are ignored):
//   0 PENDING  R: pending.           W: write-1-to-clear.
//   1 MASK     RW: 1 = source enabled.
//   2 EDGE     RW: 1 = rising-edge capture, 0 = level capture.
//   3 ACTIVE   R: pending & mask.
//   4 VECTOR   R: [15] = |active, [3:0] = lowest set index of active (0 when none).
//   5 HOLDOFF  RW: [HOLDOFF_W-1:0] = gap in cycles.
//   6 RAW      R: irq_in.
//   7 FORCE    W: write-1-to-set pending. Reads 0.
//   8..15      R: 0. Writes are ignored.
//  readdata is updated every clk from the address mux, regardless of chipselect: one cycle of read latency.
//  Pending set term per bit:
//   - Edge mode: irq_in & ~irq_in_d.
//   - Level mode: irq_in.
//   - OR'd with FORCE write bits.
//  Pending next = (pending & ~w1c) | set. If set and clear hit the same bit in the same cycle, set wins.
//  In level mode, a source that is still high re-pends on the edge after a W1C.
//  Latency: irq_in high at edge k -> pending visible after k -> irq_out=1 after k+1 (if masked in and the FSM is IDLE).
//  FSM, registered; irq_out = (state==ASSERT):
//   IDLE    -> ASSERT when |active.
//   ASSERT  -> IDLE when ~|active and holdoff==0.
//           -> GAP when ~|active and holdoff!=0; on that transition cnt <= holdoff-1.
//   GAP     -> IDLE when cnt==0, else cnt <= cnt-1. irq_out stays 0 even if active rises.
//   IDLE is reached with active already set -> ASSERT on the next edge.
//  Clearing MASK while in ASSERT deasserts irq_out after one edge; this path follows the same GAP rules.
//  A HOLDOFF write during GAP does not affect the running cnt; the new value applies to the next GAP.
//  The counter never wraps: it stops at 0.
// STRUCTURE
//  Package final_project_irq_pkg:
//   - address localparams: ADDR_PENDING .. ADDR_FORCE
//   - FSM enum: IDLE, ASSERT, GAP
//   - parameter-range check
//  Sub-module final_project_irq_prio_enc: combinational, NUM_SRC -> {valid, idx[3:0]}, lowest index wins.
//  The top level holds the register file, edge detect, pending logic, FSM and read mux.
// TESTING
//  1 Timer link: irq_in[0]=1 at edge 10, MASK=0x1, EDGE=0 -> PENDING=0x1 after edge 10, irq_out=1 after edge 11,
//    VECTOR=0x8000. W1C PENDING=0x1 with irq_in[0] still 1 -> bit re-pends and irq_out stays 1.
//  2 Edge mode: EDGE=0x4, MASK=0x4, irq_in[2] held high for 5 cycles -> PENDING=0x4 once.
//    After W1C=0x4 -> PENDING=0, irq_out=0 one edge later, no re-pend.
//  3 Priority: FORCE=0x28, MASK=0xFF -> VECTOR=0x8003. W1C=0x08 -> VECTOR=0x8005.
//    MASK=0x00 -> VECTOR=0x0000, irq_out=0 after one edge.
//  4 Holdoff: HOLDOFF=3, clear active while in ASSERT with a new source pending immediately
//    -> irq_out low for exactly 4 cycles (GAP x3 + IDLE), then high.
//  5 Simultaneous: level source high while W1C of the same bit -> bit stays 1.
//    FORCE=0x1 with MASK=0 -> PENDING=0x1, ACTIVE=0, irq_out=0.
//  6 Reset mid-GAP (HOLDOFF=100, reset at GAP cnt=50) -> all registers 0, irq_out=0, readdata=0 on the next edge;
//    unmapped address 12 reads 0.

Source files
------------

// File: rtl/final_project_soc_irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// final_project_irq_pkg
// Shared definitions for the SoC interrupt aggregator:
//   - register word indices on the 16-bit slave bus
//   - the irq_out sequencing FSM state type
//   - a legality check for the block parameters
// -----------------------------------------------------------------------------
package final_project_irq_pkg;

  localparam int BUS_W         = 16;
  localparam int NUM_SRC_MAX   = 15;  // VECTOR index field is 4 bits wide
  localparam int HOLDOFF_W_MAX = 16;  // HOLDOFF must fit in one bus word

  // Register word indices
  localparam logic [3:0] ADDR_PENDING = 4'd0;
  localparam logic [3:0] ADDR_MASK    = 4'd1;
  localparam logic [3:0] ADDR_EDGE    = 4'd2;
  localparam logic [3:0] ADDR_ACTIVE  = 4'd3;
  localparam logic [3:0] ADDR_VECTOR  = 4'd4;
  localparam logic [3:0] ADDR_HOLDOFF = 4'd5;
  localparam logic [3:0] ADDR_RAW     = 4'd6;
  localparam logic [3:0] ADDR_FORCE   = 4'd7;

  // irq_out sequencing: ASSERT drives the CPU line, GAP enforces the holdoff
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } irq_state_e;

  // True when the block parameters are inside their supported range
  function automatic bit params_legal(input int num_src, input int holdoff_w);
    return (num_src >= 1) && (num_src <= NUM_SRC_MAX) &&
           (holdoff_w >= 1) && (holdoff_w <= HOLDOFF_W_MAX);
  endfunction

endpackage

// File: rtl/final_project_soc_irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// final_project_soc_irq_ctrl_if
// Avalon-MM style 16-bit register slave bus of the interrupt aggregator.
//   address    4   register word index
//   chipselect 1   slave select
//   write_n    1   active-low write strobe (write = chipselect && ~write_n)
//   writedata  16  write data
//   readdata   16  registered read data (one cycle latency)
// master: the CPU/bus side; slave: the interrupt controller.
// -----------------------------------------------------------------------------
interface final_project_soc_irq_ctrl_if;

  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/final_project_soc_irq_ctrl_prio_enc.sv
// -----------------------------------------------------------------------------
// final_project_irq_prio_enc
// Combinational priority encoder; the lowest set request index wins.
//   req    in   NUM_SRC  request vector
//   valid  out  1        at least one request set
//   idx    out  4        lowest set index (0 when no request is set)
// -----------------------------------------------------------------------------
module final_project_irq_prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [3:0]         idx
);

  logic [3:0] idx_s;

  assign valid = |req;
  assign idx   = idx_s;

  // Scan from the top down so the last hit, i.e. the lowest index, sticks
  always_comb begin
    idx_s = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_s = 4'(i);
      end else begin
        idx_s = idx_s;
      end
    end
  end

endmodule

// File: rtl/final_project_soc_irq_ctrl.sv
// -----------------------------------------------------------------------------
// final_project_soc_irq_ctrl
// Interrupt aggregator sitting behind the interval timer(s) and other
// peripherals. Requests are latched as pending (level or rising-edge capture),
// masked, priority-encoded (lowest index wins) and presented to the CPU on a
// single irq_out with a programmable minimum low time between pulses.
//   clk      in   1        system clock
//   reset    in   1        synchronous, active-high reset
//   bus      slave         16-bit register bus (see final_project_soc_irq_ctrl_if)
//   irq_in   in   NUM_SRC  level requests, timer on bit 0, clk domain
//   irq_out  out  1        aggregated interrupt, registered
// Register map: 0 PENDING (W1C), 1 MASK, 2 EDGE, 3 ACTIVE, 4 VECTOR,
//               5 HOLDOFF, 6 RAW, 7 FORCE (W1S), 8..15 read as zero.
// -----------------------------------------------------------------------------
module final_project_soc_irq_ctrl
  import final_project_irq_pkg::*;
#(
  parameter int NUM_SRC   = 8,
  parameter int HOLDOFF_W = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  final_project_soc_irq_ctrl_if.slave        bus,
  input  logic [NUM_SRC-1:0]                 irq_in,
  output logic                               irq_out
);

  generate
    if (!params_legal(NUM_SRC, HOLDOFF_W)) begin : g_bad_params
      $error("final_project_soc_irq_ctrl: NUM_SRC must be 1..15 and HOLDOFF_W 1..16");
    end
  endgenerate

  localparam logic [HOLDOFF_W-1:0] HOLD_ONE = HOLDOFF_W'(1);

  // Architectural state
  logic [NUM_SRC-1:0]   pending_r;
  logic [NUM_SRC-1:0]   mask_r;
  logic [NUM_SRC-1:0]   edge_sel_r;
  logic [NUM_SRC-1:0]   irq_in_d_r;
  logic [HOLDOFF_W-1:0] holdoff_r;
  logic [HOLDOFF_W-1:0] cnt_r;
  irq_state_e           state_r;
  logic [15:0]          readdata_r;
  logic                 irq_out_r;

  // Decode and next-state terms
  logic                 wr_s;
  logic [NUM_SRC-1:0]   wdata_src_s;
  logic [NUM_SRC-1:0]   w1c_s;
  logic [NUM_SRC-1:0]   force_s;
  logic [NUM_SRC-1:0]   set_s;
  logic [NUM_SRC-1:0]   pending_nxt_s;
  logic [NUM_SRC-1:0]   active_s;
  logic                 act_valid_s;
  logic [3:0]           act_idx_s;
  logic [15:0]          rd_mux_s;

  assign wr_s        = bus.chipselect & ~bus.write_n;
  assign wdata_src_s = bus.writedata[NUM_SRC-1:0];

  assign w1c_s   = (wr_s && (bus.address == ADDR_PENDING)) ? wdata_src_s : '0;
  assign force_s = (wr_s && (bus.address == ADDR_FORCE))   ? wdata_src_s : '0;

  // Edge-mode bits capture only rising edges, level-mode bits capture while high
  assign set_s = (edge_sel_r & irq_in & ~irq_in_d_r)
               | (~edge_sel_r & irq_in)
               | force_s;

  // Set is OR'd after the clear so a simultaneous set keeps the bit pending
  assign pending_nxt_s = (pending_r & ~w1c_s) | set_s;

  assign active_s = pending_r & mask_r;

  final_project_irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req   (active_s),
    .valid (act_valid_s),
    .idx   (act_idx_s)
  );

  // Read mux over the current register contents; unmapped words read zero
  always_comb begin
    rd_mux_s = 16'h0000;
    case (bus.address)
      ADDR_PENDING: rd_mux_s = 16'(pending_r);
      ADDR_MASK:    rd_mux_s = 16'(mask_r);
      ADDR_EDGE:    rd_mux_s = 16'(edge_sel_r);
      ADDR_ACTIVE:  rd_mux_s = 16'(active_s);
      ADDR_VECTOR:  rd_mux_s = {act_valid_s, 11'd0, act_idx_s};
      ADDR_HOLDOFF: rd_mux_s = 16'(holdoff_r);
      ADDR_RAW:     rd_mux_s = 16'(irq_in);
      ADDR_FORCE:   rd_mux_s = 16'h0000;
      default:      rd_mux_s = 16'h0000;
    endcase
  end

  // Register file, edge-detect history, pending bits and read data register
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r  <= '0;
      mask_r     <= '0;
      edge_sel_r <= '0;
      irq_in_d_r <= '0;
      holdoff_r  <= '0;
      readdata_r <= 16'h0000;
    end else begin
      pending_r  <= pending_nxt_s;
      irq_in_d_r <= irq_in;
      readdata_r <= rd_mux_s;
      if (wr_s && (bus.address == ADDR_MASK)) begin
        mask_r <= wdata_src_s;
      end else begin
        mask_r <= mask_r;
      end
      if (wr_s && (bus.address == ADDR_EDGE)) begin
        edge_sel_r <= wdata_src_s;
      end else begin
        edge_sel_r <= edge_sel_r;
      end
      if (wr_s && (bus.address == ADDR_HOLDOFF)) begin
        holdoff_r <= bus.writedata[HOLDOFF_W-1:0];
      end else begin
        holdoff_r <= holdoff_r;
      end
    end
  end

  // irq_out sequencer: assert on any active source, then hold low for the
  // programmed gap after deassertion; HOLDOFF is sampled only on GAP entry
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      irq_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (act_valid_s) begin
            state_r   <= ASSERT;
            irq_out_r <= 1'b1;
          end else begin
            state_r   <= IDLE;
            irq_out_r <= 1'b0;
          end
        end
        ASSERT: begin
          if (!act_valid_s) begin
            irq_out_r <= 1'b0;
            if (holdoff_r == '0) begin
              state_r <= IDLE;
            end else begin
              state_r <= GAP;
              cnt_r   <= holdoff_r - HOLD_ONE;
            end
          end else begin
            state_r   <= ASSERT;
            irq_out_r <= 1'b1;
          end
        end
        GAP: begin
          irq_out_r <= 1'b0;
          // cnt stops at zero; leaving GAP happens on the zero cycle
          if (cnt_r == '0) begin
            state_r <= IDLE;
          end else begin
            state_r <= GAP;
            cnt_r   <= cnt_r - HOLD_ONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= '0;
          irq_out_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.readdata = readdata_r;
  assign irq_out      = irq_out_r;

endmodule

// File: tb/tb_final_project_soc_irq_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for final_project_soc_irq_ctrl (NUM_SRC=8, HOLDOFF_W=16).
// A directed vector table, hand sequences for holdoff and mid-gap reset, and a
// randomized phase all run against a behavioural model of the register map and
// of the irq_out timing (earliest reassert edge = deassert edge + HOLDOFF + 1).
// -----------------------------------------------------------------------------
module tb_final_project_soc_irq_ctrl;

  localparam logic [15:0] SRC = 16'h00FF;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  logic       irq_out;

  final_project_soc_irq_ctrl_if bus ();

  final_project_soc_irq_ctrl #(
    .NUM_SRC   (8),
    .HOLDOFF_W (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .irq_in  (irq_in),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  logic [15:0] m_pend = 16'h0, m_mask = 16'h0, m_edge = 16'h0, m_hold = 16'h0;
  logic [15:0] m_prev = 16'h0, m_rd = 16'h0;
  bit          m_irq = 1'b0;
  int          m_ready_edge = 0;
  int          n_edge = 0;

  function automatic logic [15:0] model_read(input logic [3:0] a);
    logic [15:0] act;
    act = m_pend & m_mask;
    case (a)
      4'd0: return m_pend;
      4'd1: return m_mask;
      4'd2: return m_edge;
      4'd3: return act;
      4'd4: begin
        for (int i = 0; i < 16; i++) begin
          if (act[i]) return 16'h8000 | 16'(i);
        end
        return 16'h0000;
      end
      4'd5: return m_hold;
      4'd6: return {8'h00, irq_in};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_edge();
    logic [15:0] act, in16, w1c, frc, setv, wd;
    logic        wr;
    act  = m_pend & m_mask;
    in16 = {8'h00, irq_in};
    wd   = bus.writedata;
    wr   = bus.chipselect && !bus.write_n;
    if (reset) begin
      m_pend = 16'h0; m_mask = 16'h0; m_edge = 16'h0; m_hold = 16'h0;
      m_prev = 16'h0; m_rd = 16'h0; m_irq = 1'b0; m_ready_edge = 0;
    end else begin
      m_rd = model_read(bus.address);
      if (m_irq) begin
        if (act == 16'h0) begin
          m_irq = 1'b0;
          m_ready_edge = n_edge + int'(m_hold) + 1;
        end
      end else if (act != 16'h0 && n_edge >= m_ready_edge) begin
        m_irq = 1'b1;
      end
      w1c  = (wr && bus.address == 4'd0) ? (wd & SRC) : 16'h0;
      frc  = (wr && bus.address == 4'd7) ? (wd & SRC) : 16'h0;
      setv = (m_edge & in16 & ~m_prev) | (~m_edge & in16) | frc;
      m_pend = (m_pend & ~w1c) | setv;
      if (wr && bus.address == 4'd1) m_mask = wd & SRC;
      if (wr && bus.address == 4'd2) m_edge = wd & SRC;
      if (wr && bus.address == 4'd5) m_hold = wd;
      m_prev = in16;
    end
    n_edge++;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic w, input logic [15:0] d, input logic [7:0] q);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = ~w;
    bus.writedata  = d;
    irq_in         = q;
  endtask

  // One clock edge; model follows the edge, outputs compared 1 time unit later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check16("model_readdata", bus.readdata, m_rd);
    check1("model_irq_out", irq_out, m_irq);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic [3:0]  addr;
    logic        wr;
    logic [15:0] wdata;
    logic [7:0]  irq;
    logic [15:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string n, input logic [3:0] a, input logic w,
                              input logic [15:0] d, input logic [7:0] q,
                              input logic [15:0] er, input logic ei);
    vec_t v;
    v.name = n; v.addr = a; v.wr = w; v.wdata = d; v.irq = q; v.exp_rd = er; v.exp_irq = ei;
    return v;
  endfunction

  logic [3:0]  r_addr;
  logic [15:0] r_data;
  logic [7:0]  r_irq;
  int          lows;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // timer link, level capture, simultaneous set/clear
    tbl.push_back(mk("t1_mask",      4'd1, 1'b1, 16'h0001, 8'h00, 16'h0000, 1'b0));
    tbl.push_back(mk("t1_src_hi",    4'd0, 1'b0, 16'h0000, 8'h01, 16'h0000, 1'b0));
    tbl.push_back(mk("t1_pend",      4'd0, 1'b0, 16'h0000, 8'h01, 16'h0001, 1'b1));
    tbl.push_back(mk("t1_vec",       4'd4, 1'b0, 16'h0000, 8'h01, 16'h8000, 1'b1));
    tbl.push_back(mk("t1_w1c",       4'd0, 1'b1, 16'h0001, 8'h01, 16'h0001, 1'b1));
    tbl.push_back(mk("t1_repend",    4'd0, 1'b0, 16'h0000, 8'h01, 16'h0001, 1'b1));
    tbl.push_back(mk("t1_unmask",    4'd1, 1'b1, 16'h0000, 8'h00, 16'h0001, 1'b1));
    tbl.push_back(mk("t1_clr",       4'd0, 1'b1, 16'h0001, 8'h00, 16'h0001, 1'b0));
    tbl.push_back(mk("t1_empty",     4'd0, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0));
    // edge capture
    tbl.push_back(mk("t2_edge",      4'd2, 1'b1, 16'h0004, 8'h00, 16'h0000, 1'b0));
    tbl.push_back(mk("t2_mask",      4'd1, 1'b1, 16'h0004, 8'h00, 16'h0000, 1'b0));
    tbl.push_back(mk("t2_rise",      4'd0, 1'b0, 16'h0000, 8'h04, 16'h0000, 1'b0));
    tbl.push_back(mk("t2_pend",      4'd0, 1'b0, 16'h0000, 8'h04, 16'h0004, 1'b1));
    tbl.push_back(mk("t2_hold3",     4'd0, 1'b0, 16'h0000, 8'h04, 16'h0004, 1'b1));
    tbl.push_back(mk("t2_hold4",     4'd0, 1'b0, 16'h0000, 8'h04, 16'h0004, 1'b1));
    tbl.push_back(mk("t2_hold5",     4'd0, 1'b0, 16'h0000, 8'h04, 16'h0004, 1'b1));
    tbl.push_back(mk("t2_w1c",       4'd0, 1'b1, 16'h0004, 8'h04, 16'h0004, 1'b1));
    tbl.push_back(mk("t2_cleared",   4'd0, 1'b0, 16'h0000, 8'h04, 16'h0000, 1'b0));
    tbl.push_back(mk("t2_norepend",  4'd0, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0));
    tbl.push_back(mk("t2_edge_off",  4'd2, 1'b1, 16'h0000, 8'h00, 16'h0004, 1'b0));
    tbl.push_back(mk("t2_mask_off",  4'd1, 1'b1, 16'h0000, 8'h00, 16'h0004, 1'b0));
    // priority
    tbl.push_back(mk("t3_force",     4'd7, 1'b1, 16'h0028, 8'h00, 16'h0000, 1'b0));
    tbl.push_back(mk("t3_mask",      4'd1, 1'b1, 16'h00FF, 8'h00, 16'h0000, 1'b0));
    tbl.push_back(mk("t3_vec3",      4'd4, 1'b0, 16'h0000, 8'h00, 16'h8003, 1'b1));
    tbl.push_back(mk("t3_w1c8",      4'd0, 1'b1, 16'h0008, 8'h00, 16'h0028, 1'b1));
    tbl.push_back(mk("t3_vec5",      4'd4, 1'b0, 16'h0000, 8'h00, 16'h8005, 1'b1));
    tbl.push_back(mk("t3_mask0",     4'd1, 1'b1, 16'h0000, 8'h00, 16'h00FF, 1'b1));
    tbl.push_back(mk("t3_vec0",      4'd4, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0));
    tbl.push_back(mk("t3_flush",     4'd0, 1'b1, 16'h00FF, 8'h00, 16'h0020, 1'b0));
    tbl.push_back(mk("t3_active0",   4'd3, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0));
    // force with mask off, RAW, unmapped words, upper bits, HOLDOFF rw
    tbl.push_back(mk("t5_force",     4'd7, 1'b1, 16'h0001, 8'h00, 16'h0000, 1'b0));
    tbl.push_back(mk("t5_pend1",     4'd0, 1'b0, 16'h0000, 8'h00, 16'h0001, 1'b0));
    tbl.push_back(mk("t5_active0",   4'd3, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0));
    tbl.push_back(mk("t5_raw",       4'd6, 1'b0, 16'h0000, 8'h05, 16'h0005, 1'b0));
    tbl.push_back(mk("t5_flush",     4'd0, 1'b1, 16'hFFFF, 8'h00, 16'h0005, 1'b0));
    tbl.push_back(mk("t5_unm_wr",    4'd12, 1'b1, 16'hFFFF, 8'h00, 16'h0000, 1'b0));
    tbl.push_back(mk("t5_pend0",     4'd0, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0));
    tbl.push_back(mk("t5_mask_hi",   4'd1, 1'b1, 16'hFF00, 8'h00, 16'h0000, 1'b0));
    tbl.push_back(mk("t5_mask_rd",   4'd1, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0));
    tbl.push_back(mk("t5_hold_wr",   4'd5, 1'b1, 16'hABCD, 8'h00, 16'h0000, 1'b0));
    tbl.push_back(mk("t5_hold_rd",   4'd5, 1'b0, 16'h0000, 8'h00, 16'hABCD, 1'b0));
    tbl.push_back(mk("t5_hold_clr",  4'd5, 1'b1, 16'h0000, 8'h00, 16'hABCD, 1'b0));
    tbl.push_back(mk("t5_unmapped",  4'd12, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0));
    tbl.push_back(mk("t5_force_rd",  4'd7, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0));

    // ---- reset ----
    reset = 1'b1;
    drive(4'd0, 1'b0, 16'h0000, 8'h00);
    repeat (3) step();
    check16("reset_readdata", bus.readdata, 16'h0000);
    check1("reset_irq_out", irq_out, 1'b0);
    reset = 1'b0;

    // ---- directed table ----
    foreach (tbl[i]) begin
      drive(tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].irq);
      step();
      check16(tbl[i].name, bus.readdata, tbl[i].exp_rd);
      check1({tbl[i].name, "_irq"}, irq_out, tbl[i].exp_irq);
    end

    // ---- holdoff gap: HOLDOFF=3, new source pending right after clear ----
    drive(4'd5, 1'b1, 16'h0003, 8'h00); step();
    drive(4'd1, 1'b1, 16'h0003, 8'h00); step();
    drive(4'd7, 1'b1, 16'h0001, 8'h00); step();
    drive(4'd4, 1'b0, 16'h0000, 8'h00); step();
    check1("t4_assert", irq_out, 1'b1);
    drive(4'd0, 1'b1, 16'h0001, 8'h00); step();
    check1("t4_still_high", irq_out, 1'b1);
    drive(4'd7, 1'b1, 16'h0002, 8'h00); step();
    lows = 0;
    for (int k = 0; k < 20 && irq_out == 1'b0; k++) begin
      lows++;
      // HOLDOFF rewritten mid-gap must not disturb the running gap
      if (k == 0) drive(4'd5, 1'b1, 16'h0001, 8'h00);
      else        drive(4'd4, 1'b0, 16'h0000, 8'h00);
      step();
    end
    check_int("t4_gap_len_h3", lows, 4);
    // next gap uses the new HOLDOFF=1
    drive(4'd0, 1'b1, 16'h0002, 8'h00); step();
    drive(4'd7, 1'b1, 16'h0001, 8'h00); step();
    lows = 0;
    for (int k = 0; k < 20 && irq_out == 1'b0; k++) begin
      lows++;
      drive(4'd4, 1'b0, 16'h0000, 8'h00);
      step();
    end
    check_int("t4_gap_len_h1", lows, 2);
    drive(4'd1, 1'b1, 16'h0000, 8'h00); step();
    drive(4'd0, 1'b1, 16'h00FF, 8'h00); step();
    drive(4'd4, 1'b0, 16'h0000, 8'h00); repeat (4) step();

    // ---- reset in the middle of a long gap ----
    drive(4'd5, 1'b1, 16'd100, 8'h00); step();
    drive(4'd1, 1'b1, 16'h0001, 8'h00); step();
    drive(4'd7, 1'b1, 16'h0001, 8'h00); step();
    drive(4'd4, 1'b0, 16'h0000, 8'h00); step();
    drive(4'd0, 1'b1, 16'h0001, 8'h00); step();
    drive(4'd5, 1'b0, 16'h0000, 8'h00); step();   // GAP entered, cnt=99
    repeat (49) step();                           // cnt=50
    check1("t6_in_gap", irq_out, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check16("t6_rd_after_rst", bus.readdata, 16'h0000);
    check1("t6_irq_after_rst", irq_out, 1'b0);
    for (int a = 0; a < 16; a++) begin
      drive(4'(a), 1'b0, 16'h0000, 8'h00);
      step();
      check16("t6_reg_zero", bus.readdata, 16'h0000);
    end
    drive(4'd1, 1'b1, 16'h0001, 8'h00); step();
    drive(4'd7, 1'b1, 16'h0001, 8'h00); step();
    drive(4'd4, 1'b0, 16'h0000, 8'h00); step();
    check1("t6_idle_after_rst", irq_out, 1'b1);
    drive(4'd1, 1'b1, 16'h0000, 8'h00); step();
    drive(4'd0, 1'b1, 16'h00FF, 8'h00); step();

    // ---- randomized phase against the model ----
    r_irq = 8'h00;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) r_addr = 4'($urandom_range(0, 15));
      else                           r_addr = 4'($urandom_range(0, 7));
      r_data = 16'($urandom);
      if (r_addr == 4'd5) r_data = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) r_irq = 8'($urandom);
      bus.address    = r_addr;
      bus.chipselect = 1'($urandom_range(0, 1));
      bus.write_n    = ($urandom_range(0, 2) != 0);
      bus.writedata  = r_data;
      irq_in         = r_irq;
      reset          = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
